// File: rtl/xgmii_66b_encoder_64.sv
// 64b/66b PCS transmit encoder: classifies one XGMII word per clock, checks
// frame sequencing, and registers one 66-bit block (header + payload).
// Optional build macro: XGMII_ENC_SCRAMBLE_EN adds the x^58+x^39+1
// self-synchronous payload scrambler inside the same register stage.
//
// state  | meaning
// INIT   | out of reset, nothing judged yet
// C      | between frames (idle / control blocks)
// D      | inside a frame after a start
// E      | last block emitted was an error block
module xgmii_66b_encoder_64 #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH/8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    xgmii_txd,
  input  logic [CTRL_WIDTH-1:0]    xgmii_txc,
  input  logic                     cfg_tx_enable,
  output logic [DATA_WIDTH-1:0]    encoded_tx_data,
  output logic [1:0]               encoded_tx_hdr,
  output logic                     tx_bad_block,
  output logic [ERR_CNT_WIDTH-1:0] tx_err_count
);

  localparam logic [7:0]  CH_IDLE    = 8'h07;
  localparam logic [7:0]  CH_ERR     = 8'hFE;
  localparam logic [7:0]  CH_START   = 8'hFB;
  localparam logic [7:0]  CH_TERM    = 8'hFD;
  localparam logic [1:0]  HDR_DATA   = 2'b01;
  localparam logic [1:0]  HDR_CTRL   = 2'b10;
  localparam logic [63:0] IDLE_BLOCK = 64'h0000_0000_0000_001E;
  localparam logic [63:0] ERR_BLOCK  = {{8{7'h1E}}, 8'h1E};

  typedef enum logic [1:0] {ST_INIT, ST_C, ST_D, ST_E} state_t;
  typedef enum logic [2:0] {K_C, K_S, K_D, K_T, K_E} kind_t;

  state_t                   state_q, state_d;
  kind_t                    kind;
  logic [7:0]               lane_ie;
  logic [6:0]               lane_code [8];
  logic [63:0]              enc_payload;
  logic [63:0]              blk_payload;
  logic [63:0]              encoded_tx_data_q, encoded_tx_data_d;
  logic [1:0]               encoded_tx_hdr_q, encoded_tx_hdr_d;
  logic                     tx_bad_block_q, tx_bad_block_d;
  logic [ERR_CNT_WIDTH-1:0] tx_err_count_q, tx_err_count_d;

  function automatic logic [7:0] term_type(input int n);
    case (n)
      0:       term_type = 8'h87;
      1:       term_type = 8'h99;
      2:       term_type = 8'hAA;
      3:       term_type = 8'hB4;
      4:       term_type = 8'hCC;
      5:       term_type = 8'hD2;
      6:       term_type = 8'hE1;
      default: term_type = 8'hFF;
    endcase
  endfunction

  // Per-lane idle/error detection and 7-bit control code mapping.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      lane_ie[k]   = (xgmii_txd[8*k +: 8] == CH_IDLE) || (xgmii_txd[8*k +: 8] == CH_ERR);
      lane_code[k] = (xgmii_txd[8*k +: 8] == CH_ERR) ? 7'h1E : 7'h00;
    end
  end

  // Word classification and control-block payload packing.
  always_comb begin
    kind        = K_E;
    enc_payload = '0;
    if (xgmii_txc == 8'h00) begin
      kind        = K_D;
      enc_payload = xgmii_txd;
    end else if ((xgmii_txc == 8'hFF) && (&lane_ie)) begin
      kind             = K_C;
      enc_payload[7:0] = 8'h1E;
      for (int j = 0; j < 8; j++) enc_payload[7*j+8 +: 7] = lane_code[j];
    end else if ((xgmii_txc == 8'h01) && (xgmii_txd[7:0] == CH_START)) begin
      kind        = K_S;
      enc_payload = {xgmii_txd[63:8], 8'h78};
    end else if ((xgmii_txc == 8'h1F) && (&lane_ie[3:0]) && (xgmii_txd[39:32] == CH_START)) begin
      kind               = K_S;
      enc_payload[7:0]   = 8'h33;
      for (int j = 0; j < 4; j++) enc_payload[7*j+8 +: 7] = lane_code[j];
      enc_payload[63:40] = xgmii_txd[63:40];
    end else begin
      // At most one n can match because each Tn has a unique txc mask.
      for (int n = 0; n < 8; n++) begin
        if ((xgmii_txc == (8'hFF << n)) && (xgmii_txd[8*n +: 8] == CH_TERM) &&
            ((lane_ie & (8'hFE << n)) == (8'hFE << n))) begin
          kind             = K_T;
          enc_payload[7:0] = term_type(n);
          for (int k = 0; k < 7; k++)
            if (k < n) enc_payload[8*k+8 +: 8] = xgmii_txd[8*k +: 8];
          for (int k = 1; k < 8; k++)
            if (k > n) enc_payload[7*k+8 +: 7] = lane_code[k];
        end
      end
    end
  end

  // Transmit sequencing FSM, block selection and error counting.
  always_comb begin
    state_d        = state_q;
    tx_bad_block_d = 1'b0;
    blk_payload    = enc_payload;
    case (state_q)
      ST_INIT, ST_C: begin
        case (kind)
          K_C:     state_d = ST_C;
          K_S:     state_d = ST_D;
          default: state_d = ST_E;
        endcase
      end
      ST_D: begin
        case (kind)
          K_D:     state_d = ST_D;
          K_T:     state_d = ST_C;
          default: state_d = ST_E;
        endcase
      end
      default: begin
        case (kind)
          K_D, K_S: state_d = ST_D;
          K_T, K_C: state_d = ST_C;
          default:  state_d = ST_E;
        endcase
      end
    endcase

    if (!cfg_tx_enable) begin
      // Disabled link: idle out, drop any frame in progress.
      state_d          = ST_C;
      blk_payload      = IDLE_BLOCK;
      encoded_tx_hdr_d = HDR_CTRL;
    end else if (state_d == ST_E) begin
      tx_bad_block_d   = 1'b1;
      blk_payload      = ERR_BLOCK;
      encoded_tx_hdr_d = HDR_CTRL;
    end else begin
      encoded_tx_hdr_d = (kind == K_D) ? HDR_DATA : HDR_CTRL;
    end

    tx_err_count_d = tx_err_count_q;
    if (tx_bad_block_d && !(&tx_err_count_q)) tx_err_count_d = tx_err_count_q + 1'b1;
  end

`ifdef XGMII_ENC_SCRAMBLE_EN
  logic [57:0] scr_q, scr_d;

  // Bit-serial scrambler unrolled over the block; bit 0 leaves first.
  always_comb begin
    scr_d             = scr_q;
    encoded_tx_data_d = '0;
    for (int i = 0; i < 64; i++) begin
      encoded_tx_data_d[i] = blk_payload[i] ^ scr_d[38] ^ scr_d[57];
      scr_d                = {scr_d[56:0], encoded_tx_data_d[i]};
    end
  end

  // Scrambler history register, seeded with all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scr_q <= '1;
    else        scr_q <= scr_d;
  end
`else
  // Raw payload path.
  always_comb begin
    encoded_tx_data_d = blk_payload;
  end
`endif

  // Output block, status and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_INIT;
      encoded_tx_data_q <= IDLE_BLOCK;
      encoded_tx_hdr_q  <= HDR_CTRL;
      tx_bad_block_q    <= 1'b0;
      tx_err_count_q    <= '0;
    end else begin
      state_q           <= state_d;
      encoded_tx_data_q <= encoded_tx_data_d;
      encoded_tx_hdr_q  <= encoded_tx_hdr_d;
      tx_bad_block_q    <= tx_bad_block_d;
      tx_err_count_q    <= tx_err_count_d;
    end
  end

  assign encoded_tx_data = encoded_tx_data_q;
  assign encoded_tx_hdr  = encoded_tx_hdr_q;
  assign tx_bad_block    = tx_bad_block_q;
  assign tx_err_count    = tx_err_count_q;

endmodule

// File: tb/tb_xgmii_66b_encoder_64.sv
// Bench for xgmii_66b_encoder_64: directed XGMII words, a block-level model
// checked every cycle, and literal expectations at key points.
module tb_xgmii_66b_encoder_64;

  localparam int          CW    = 4;
  localparam logic [63:0] IDLEW = 64'h0707_0707_0707_0707;
  localparam logic [63:0] IDLEB = 64'h0000_0000_0000_001E;
  localparam logic [63:0] ERRB  = 64'h3C78_F1E3_C78F_1E1E;
  localparam logic [63:0] BADW  = 64'h0707_0707_0707_079C;
  localparam int K_C = 0, K_S = 1, K_D = 2, K_T = 3, K_E = 4;
  localparam int M_INIT = 0, M_C = 1, M_D = 2, M_E = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   txd = IDLEW;
  logic [7:0]    txc = 8'hFF;
  logic          en = 1'b1;
  logic [63:0]   encoded_tx_data;
  logic [1:0]    encoded_tx_hdr;
  logic          tx_bad_block;
  logic [CW-1:0] tx_err_count;

  int pass_cnt = 0, total_cnt = 0;
  bit chk_on = 0;

  logic [7:0] ttype [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

  int          m_st, e_cnt;
  logic [63:0] e_data;
  logic [1:0]  e_hdr;
  logic        e_bad;
`ifdef XGMII_ENC_SCRAMBLE_EN
  bit hist [$];
`endif

  xgmii_66b_encoder_64 #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .ERR_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .xgmii_txd(txd), .xgmii_txc(txc), .cfg_tx_enable(en),
    .encoded_tx_data(encoded_tx_data), .encoded_tx_hdr(encoded_tx_hdr),
    .tx_bad_block(tx_bad_block), .tx_err_count(tx_err_count));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_encode(input logic [7:0] c, input logic [63:0] d,
                                       output int cls, output logic [63:0] p);
    logic [7:0] b [8];
    bit         ie [8];
    logic [6:0] cd [8];
    bit         all_ie, lo_ie;
    p = '0;
    cls = K_E;
    all_ie = 1;
    lo_ie = 1;
    for (int k = 0; k < 8; k++) begin
      b[k]  = d[8*k +: 8];
      ie[k] = (b[k] == 8'h07) || (b[k] == 8'hFE);
      cd[k] = (b[k] == 8'hFE) ? 7'h1E : 7'h00;
      if (!ie[k]) all_ie = 0;
      if (!ie[k] && k < 4) lo_ie = 0;
    end
    if (c == 8'h00) begin
      cls = K_D;
      p = d;
    end else if (c == 8'hFF && all_ie) begin
      cls = K_C;
      p[7:0] = 8'h1E;
      for (int j = 0; j < 8; j++) p[7*j+8 +: 7] = cd[j];
    end else if (c == 8'h01 && b[0] == 8'hFB) begin
      cls = K_S;
      p = {d[63:8], 8'h78};
    end else if (c == 8'h1F && lo_ie && b[4] == 8'hFB) begin
      cls = K_S;
      p[7:0] = 8'h33;
      for (int j = 0; j < 4; j++) p[7*j+8 +: 7] = cd[j];
      p[63:40] = d[63:40];
    end else begin
      for (int n = 0; n < 8; n++) begin
        bit ok;
        logic [7:0] mask;
        mask = 8'hFF << n;
        ok = (c == mask) && (b[n] == 8'hFD);
        for (int k = n + 1; k < 8; k++) if (!ie[k]) ok = 0;
        if (ok) begin
          cls = K_T;
          p[7:0] = ttype[n];
          for (int k = 0; k < n; k++) p[8*k+8 +: 8] = b[k];
          for (int k = n + 1; k < 8; k++) p[7*k+8 +: 7] = cd[k];
        end
      end
    end
  endfunction

  function automatic int next_state(input int st, input int cls);
    case (cls)
      K_D:     return (st == M_D || st == M_E) ? M_D : M_E;
      K_T:     return (st == M_D || st == M_E) ? M_C : M_E;
      K_C:     return (st == M_D) ? M_E : M_C;
      K_S:     return (st == M_D) ? M_E : M_D;
      default: return M_E;
    endcase
  endfunction

  // Model update on each edge, compare shortly after.
  always @(posedge clk) begin
    int cls;
    logic [63:0] p;
    if (!rst_n) begin
      m_st = M_INIT; e_cnt = 0; e_hdr = 2'b10; e_data = IDLEB; e_bad = 0;
`ifdef XGMII_ENC_SCRAMBLE_EN
      hist.delete();
      for (int i = 0; i < 58; i++) hist.push_back(1'b1);
`endif
    end else begin
      model_encode(txc, txd, cls, p);
      if (!en) begin
        m_st = M_C; e_bad = 0; e_hdr = 2'b10; p = IDLEB;
      end else begin
        m_st  = next_state(m_st, cls);
        e_bad = (m_st == M_E);
        if (e_bad) p = ERRB;
        e_hdr = (!e_bad && cls == K_D) ? 2'b01 : 2'b10;
        if (e_bad && e_cnt < (1 << CW) - 1) e_cnt++;
      end
`ifdef XGMII_ENC_SCRAMBLE_EN
      for (int i = 0; i < 64; i++) begin
        bit o;
        o = p[i] ^ hist[hist.size()-39] ^ hist[hist.size()-58];
        p[i] = o;
        hist.push_back(o);
        void'(hist.pop_front());
      end
`endif
      e_data = p;
    end
    #2;
    if (chk_on) begin
      chk("model_hdr", 64'(encoded_tx_hdr), 64'(e_hdr));
      chk("model_data", encoded_tx_data, e_data);
      chk("model_bad", 64'(tx_bad_block), 64'(e_bad));
      chk("model_cnt", 64'(tx_err_count), 64'(e_cnt));
    end
  end

  task automatic drv(input logic [7:0] c, input logic [63:0] d, input logic e = 1'b1);
    @(negedge clk);
    txc = c; txd = d; en = e;
  endtask

  task automatic pin(input string name, input logic [1:0] hdr, input logic [63:0] data,
                     input logic bad, input int cnt);
    @(posedge clk); #3;
    chk({name, "_hdr"}, 64'(encoded_tx_hdr), 64'(hdr));
`ifndef XGMII_ENC_SCRAMBLE_EN
    chk({name, "_data"}, encoded_tx_data, data);
`endif
    chk({name, "_bad"}, 64'(tx_bad_block), 64'(bad));
    chk({name, "_cnt"}, 64'(tx_err_count), 64'(cnt));
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_hdr"}, 64'(encoded_tx_hdr), 64'(2'b10));
    chk({name, "_data"}, encoded_tx_data, IDLEB);
    chk({name, "_bad"}, 64'(tx_bad_block), 64'd0);
    chk({name, "_cnt"}, 64'(tx_err_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("reset");
    chk_on = 1;
    rst_n = 1'b1;

    repeat (3) begin drv(8'hFF, IDLEW); pin("idle", 2'b10, IDLEB, 0, 0); end

    drv(8'h01, 64'h5555_5555_5555_55FB); pin("s0", 2'b10, 64'h5555_5555_5555_5578, 0, 0);
    drv(8'h00, 64'h0123_4567_89AB_CDEF); pin("d", 2'b01, 64'h0123_4567_89AB_CDEF, 0, 0);
    drv(8'hF8, 64'h0707_0707_FDAA_AAAA); pin("t3", 2'b10, 64'h0000_0000_AAAA_AAB4, 0, 0);
    drv(8'hFF, IDLEW);                   pin("idle_t3", 2'b10, IDLEB, 0, 0);
    drv(8'h1F, 64'hD5D5_D5FB_0707_0707); pin("s4", 2'b10, 64'hD5D5_D500_0000_0033, 0, 0);
    drv(8'h00, 64'hCAFE_F00D_1234_5678); pin("d2", 2'b01, 64'hCAFE_F00D_1234_5678, 0, 0);
    drv(8'h80, 64'hFD11_2233_4455_6677); pin("t7", 2'b10, 64'h1122_3344_5566_77FF, 0, 0);
    drv(8'hFF, 64'h0707_0707_07FE_0707); pin("c_err", 2'b10, 64'h0000_0000_0780_001E, 0, 0);

    drv(8'h00, 64'h1111_1111_1111_1111); pin("d_in_c", 2'b10, ERRB, 1, 1);
    drv(8'hFF, IDLEW);                   pin("idle_after_e", 2'b10, IDLEB, 0, 1);
    drv(8'hFF, BADW);                    pin("bad_ctrl", 2'b10, ERRB, 1, 2);
    drv(8'hFF, IDLEW);                   pin("idle_after_bad", 2'b10, IDLEB, 0, 2);

    drv(8'h01, 64'h5555_5555_5555_55FB);
    drv(8'h00, 64'h2222_2222_2222_2222);
    drv(8'h00, 64'h2222_2222_2222_2222, 1'b0); pin("disabled", 2'b10, IDLEB, 0, 2);
    drv(8'h00, 64'h3333_3333_3333_3333);       pin("d_after_dis", 2'b10, ERRB, 1, 3);
    drv(8'hFF, IDLEW);                         pin("idle_after_dis", 2'b10, IDLEB, 0, 3);

    for (int n = 0; n < 8; n++) begin
      logic [63:0] w;
      w = IDLEW;
      for (int k = 0; k < n; k++) w[8*k +: 8] = 8'(8'h10 + k);
      w[8*n +: 8] = 8'hFD;
      if (n < 6) w[63:56] = 8'hFE;
      drv(8'h01, 64'hA5A5_A5A5_A5A5_A5FB);
      drv(8'h00, {32'hDEAD_BEEF, 24'h0, 8'(n)});
      drv(8'hFF << n, w);
      drv(8'hFF, IDLEW);
    end

    drv(8'h01, 64'h5555_5555_5555_55FB);
    drv(8'h00, 64'h4444_4444_4444_4444);
    @(posedge clk); #4;
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    @(negedge clk); @(negedge clk);
    txc = 8'hF8; txd = 64'h0707_0707_FDAA_AAAA;
    rst_n = 1'b1;
    pin("t_from_init", 2'b10, ERRB, 1, 1);
    drv(8'hFF, IDLEW); pin("idle_post_rst", 2'b10, IDLEB, 0, 1);

    repeat (13) drv(8'hFF, BADW);
    repeat (3) begin drv(8'hFF, BADW); pin("sat", 2'b10, ERRB, 1, (1 << CW) - 1); end
    drv(8'hFF, IDLEW); pin("idle_sat", 2'b10, IDLEB, 0, (1 << CW) - 1);

    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_reset("reset2");
    rst_n = 1'b1;
    repeat (64) drv(8'hFF, IDLEW);
    @(negedge clk);
    @(negedge clk);
    chk_on = 0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
